avmm_bus_arbiter: RTL and testbench

- Two-master, one-slave Avalon-MM arbiter placed between the CPU bus master and the shared slave bus (DRAM/ROM/LSIC/UART decode fabric).
- Adds a second requester (DMA/debug master) alongside the CPU.
- Round-robin grant; the grant is held for a whole transaction: command phase plus all responses.
- Exactly one transaction is outstanding on the slave bus at any time. Responses are routed only to the owning master.

---
 rtl/avmm_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_avmm_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin grant.
// The grant is held from command phase through the last response, so only one transaction is ever outstanding.
module avmm_bus_arbiter #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  m0_address,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic [3:0]         m0_byteenable,
    input  logic [DATA_W-1:0]  m0_writedata,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,
    output logic               m0_writeresponsevalid,
    output logic [1:0]         m0_response,
    input  logic [ADDR_W-1:0]  m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic [3:0]         m1_byteenable,
    input  logic [DATA_W-1:0]  m1_writedata,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,
    output logic               m1_writeresponsevalid,
    output logic [1:0]         m1_response,
    output logic [ADDR_W-1:0]  s_address,
    output logic               s_read,
    output logic               s_write,
    output logic [BURST_W-1:0] s_burstcount,
    output logic [3:0]         s_byteenable,
    output logic [DATA_W-1:0]  s_writedata,
    input  logic               s_waitrequest,
    input  logic [DATA_W-1:0]  s_readdata,
    input  logic               s_readdatavalid,
    input  logic               s_writeresponsevalid,
    input  logic [1:0]         s_response,
    output logic [1:0]         owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [BURST_W-1:0] sat_dec(input logic [BURST_W-1:0] v);
        sat_dec = (v == '0) ? '0 : v - BURST_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic [BURST_W-1:0] outst_q, outst_d;
    logic               started_q, started_d;
    logic               is_wr_q, is_wr_d;

    logic               sel1_s, cmd_s, resp_s;
    logic               own_read_s, own_write_s, resp_dec_s;
    logic [BURST_W-1:0] own_bc_s, own_bc_eff_s, wr_cnt_s;

    assign sel1_s       = owner_q[1];
    assign cmd_s        = (state_q == CMD);
    assign resp_s       = (state_q == RESP);
    assign own_read_s   = sel1_s ? m1_read : m0_read;
    assign own_write_s  = sel1_s ? m1_write : m0_write;
    assign own_bc_s     = sel1_s ? m1_burstcount : m0_burstcount;
    assign own_bc_eff_s = (own_bc_s == '0) ? BURST_W'(1) : own_bc_s;
    // Beats still due before this accept: the full burst on the first beat, the running count after.
    assign wr_cnt_s     = started_q ? beat_q : own_bc_eff_s;
    assign resp_dec_s   = is_wr_q ? s_writeresponsevalid : s_readdatavalid;

    assign s_read       = cmd_s & own_read_s;
    assign s_write      = cmd_s & own_write_s;
    assign s_address    = cmd_s ? (sel1_s ? m1_address : m0_address) : '0;
    assign s_burstcount = cmd_s ? own_bc_s : '0;
    assign s_byteenable = cmd_s ? (sel1_s ? m1_byteenable : m0_byteenable) : 4'b0000;
    assign s_writedata  = cmd_s ? (sel1_s ? m1_writedata : m0_writedata) : '0;

    assign m0_waitrequest = (cmd_s & owner_q[0]) ? s_waitrequest : 1'b1;
    assign m1_waitrequest = (cmd_s & owner_q[1]) ? s_waitrequest : 1'b1;

    // Responses outside RESP are strays and never reach a master.
    assign m0_readdata           = (resp_s & owner_q[0]) ? s_readdata : '0;
    assign m0_readdatavalid      = resp_s & owner_q[0] & s_readdatavalid;
    assign m0_writeresponsevalid = resp_s & owner_q[0] & s_writeresponsevalid;
    assign m0_response           = (resp_s & owner_q[0]) ? s_response : 2'b00;
    assign m1_readdata           = (resp_s & owner_q[1]) ? s_readdata : '0;
    assign m1_readdatavalid      = resp_s & owner_q[1] & s_readdatavalid;
    assign m1_writeresponsevalid = resp_s & owner_q[1] & s_writeresponsevalid;
    assign m1_response           = (resp_s & owner_q[1]) ? s_response : 2'b00;

    assign owner = owner_q;

    // Next-state logic for arbitration, command tracking and response counting.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        outst_d      = outst_q;
        started_d    = started_q;
        is_wr_d      = is_wr_q;
        case (state_q)
            IDLE: begin
                started_d = 1'b0;
                if ((m0_read | m0_write) && (m1_read | m1_write)) begin
                    owner_d = last_grant_q ? 2'b01 : 2'b10;
                    state_d = CMD;
                end else if (m0_read | m0_write) begin
                    owner_d = 2'b01;
                    state_d = CMD;
                end else if (m1_read | m1_write) begin
                    owner_d = 2'b10;
                    state_d = CMD;
                end else begin
                    owner_d = 2'b00;
                end
            end
            CMD: begin
                if (!started_q && !own_read_s && !own_write_s) begin
                    last_grant_d = sel1_s;
                    owner_d      = 2'b00;
                    state_d      = IDLE;
                end else if (!started_q && own_read_s && !s_waitrequest) begin
                    is_wr_d = 1'b0;
                    outst_d = own_bc_eff_s;
                    state_d = RESP;
                end else if (own_write_s && !s_waitrequest) begin
                    is_wr_d   = 1'b1;
                    started_d = 1'b1;
                    beat_d    = sat_dec(wr_cnt_s);
                    if (wr_cnt_s <= BURST_W'(1)) begin
                        outst_d = BURST_W'(1);
                        state_d = RESP;
                    end else begin
                        state_d = CMD;
                    end
                end else begin
                    state_d = CMD;
                end
            end
            RESP: begin
                if (resp_dec_s) begin
                    outst_d = sat_dec(outst_q);
                    if (outst_q <= BURST_W'(1)) begin
                        last_grant_d = sel1_s;
                        owner_d      = 2'b00;
                        state_d      = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                owner_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 2'b00;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            outst_q      <= '0;
            started_q    <= 1'b0;
            is_wr_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            outst_q      <= outst_d;
            started_q    <= started_d;
            is_wr_q      <= is_wr_d;
        end
    end

endmodule

// File: tb/tb_avmm_bus_arbiter.sv
// Directed, table-driven bench for avmm_bus_arbiter with hand sequences for arbitration corner cases.
`timescale 1ns/1ps
module tb_avmm_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] m_addr [2];
    logic [1:0]  m_read, m_write;
    logic [4:0]  m_bc [2];
    logic [3:0]  m_be [2];
    logic [31:0] m_wdata [2];
    logic [1:0]  m_wait, m_rdv, m_wrv;
    logic [31:0] m_rdata [2];
    logic [1:0]  m_resp [2];
    logic [29:0] s_address;
    logic        s_read, s_write;
    logic [4:0]  s_burstcount;
    logic [3:0]  s_byteenable;
    logic [31:0] s_writedata;
    logic        s_waitrequest, s_rdv, s_wrv;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic [1:0]  owner;

    int tests = 0;
    int fails = 0;
    logic        mon_en = 1'b0;
    logic [31:0] acc_q [$];

    typedef struct {
        int          mst;
        bit          wr;
        logic [4:0]  bc;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
    } vec_t;

    vec_t vecs [5];

    avmm_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_address(m_addr[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
        .m0_burstcount(m_bc[0]), .m0_byteenable(m_be[0]), .m0_writedata(m_wdata[0]),
        .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdata[0]), .m0_readdatavalid(m_rdv[0]),
        .m0_writeresponsevalid(m_wrv[0]), .m0_response(m_resp[0]),
        .m1_address(m_addr[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
        .m1_burstcount(m_bc[1]), .m1_byteenable(m_be[1]), .m1_writedata(m_wdata[1]),
        .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdata[1]), .m1_readdatavalid(m_rdv[1]),
        .m1_writeresponsevalid(m_wrv[1]), .m1_response(m_resp[1]),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_burstcount(s_burstcount), .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest), .s_readdata(s_rdata), .s_readdatavalid(s_rdv),
        .s_writeresponsevalid(s_wrv), .s_response(s_resp),
        .owner(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && s_write && !s_waitrequest) acc_q.push_back(s_writedata);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_read[i] = 1'b0; m_write[i] = 1'b0;
            m_bc[i] = 5'd1; m_be[i] = 4'hF; m_wdata[i] = '0;
        end
        s_waitrequest = 1'b0; s_rdv = 1'b0; s_wrv = 1'b0; s_rdata = '0; s_resp = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic run_xact(input vec_t v);
        int n;
        int o;
        n = (v.bc == 5'd0) ? 1 : int'(v.bc);
        o = 1 - v.mst;
        m_addr[v.mst] = v.addr; m_bc[v.mst] = v.bc; m_be[v.mst] = v.be; m_wdata[v.mst] = v.wdata;
        if (v.wr) m_write[v.mst] = 1'b1; else m_read[v.mst] = 1'b1;
        s_waitrequest = 1'b0;
        #1;
        chk("idle_wait", m_wait[v.mst], 1'b1);
        chk("idle_no_cmd", {s_read, s_write}, 2'b00);
        tick();
        chk("grant", owner, (v.mst == 1) ? 2'b10 : 2'b01);
        chk("cmd_read", s_read, !v.wr);
        chk("cmd_write", s_write, v.wr);
        chk("cmd_addr", s_address, v.addr);
        chk("cmd_bc", s_burstcount, v.bc);
        chk("cmd_be", s_byteenable, v.be);
        chk("other_wait", m_wait[o], 1'b1);
        chk("own_wait", m_wait[v.mst], 1'b0);
        if (v.wr) begin
            for (int k = 0; k < n; k++) begin
                m_wdata[v.mst] = v.wdata + 32'(k);
                #1;
                chk("wdata", s_writedata, v.wdata + 32'(k));
                tick();
            end
        end else begin
            tick();
        end
        m_read[v.mst] = 1'b0; m_write[v.mst] = 1'b0;
        #1;
        chk("resp_no_cmd", {s_read, s_write}, 2'b00);
        chk("resp_wait", m_wait, 2'b11);
        for (int k = 0; k < v.lat; k++) begin
            chk("lat_quiet", {m_rdv, m_wrv}, 4'b0000);
            tick();
        end
        if (!v.wr) begin
            for (int k = 0; k < n; k++) begin
                s_rdv = 1'b1; s_rdata = v.rdata + 32'(k); s_resp = v.resp;
                #1;
                chk("rdv_own", m_rdv[v.mst], 1'b1);
                chk("rdata_own", m_rdata[v.mst], v.rdata + 32'(k));
                chk("resp_own", m_resp[v.mst], v.resp);
                chk("rdv_other", m_rdv[o], 1'b0);
                chk("rdata_other", m_rdata[o], 32'd0);
                tick();
            end
        end else begin
            s_wrv = 1'b1; s_resp = v.resp;
            #1;
            chk("wrv_own", m_wrv[v.mst], 1'b1);
            chk("wresp_own", m_resp[v.mst], v.resp);
            chk("wrv_other", m_wrv[o], 1'b0);
            tick();
        end
        s_rdv = 1'b0; s_wrv = 1'b0; s_rdata = '0; s_resp = 2'b00;
        #1;
        chk("back_idle", owner, 2'b00);
        tick();
    endtask

    initial begin
        vecs[0] = '{mst: 0, wr: 1'b0, bc: 5'd1,  addr: 30'h100,      be: 4'hF,    wdata: 32'h0,        rdata: 32'hDEADBEEF, resp: 2'b00, lat: 2};
        vecs[1] = '{mst: 1, wr: 1'b0, bc: 5'd0,  addr: 30'h2000,     be: 4'hF,    wdata: 32'h0,        rdata: 32'h12345678, resp: 2'b11, lat: 0};
        vecs[2] = '{mst: 0, wr: 1'b1, bc: 5'd3,  addr: 30'h3FFFFFFF, be: 4'b1100, wdata: 32'hA5A50000, rdata: 32'h0,        resp: 2'b00, lat: 1};
        vecs[3] = '{mst: 1, wr: 1'b1, bc: 5'd16, addr: 30'h40,       be: 4'hF,    wdata: 32'h00000000, rdata: 32'h0,        resp: 2'b01, lat: 0};
        vecs[4] = '{mst: 0, wr: 1'b0, bc: 5'd4,  addr: 30'h8,        be: 4'b0001, wdata: 32'h0,        rdata: 32'h11110000, resp: 2'b10, lat: 0};

        clear_inputs();
        do_reset();
        #1;
        chk("rst_owner", owner, 2'b00);
        chk("rst_wait", m_wait, 2'b11);
        chk("rst_cmd", {s_read, s_write}, 2'b00);
        chk("rst_addr", s_address, 30'd0);
        chk("rst_wdata", s_writedata, 32'd0);
        chk("rst_bc", s_burstcount, 5'd0);
        chk("rst_valids", {m_rdv, m_wrv}, 4'b0000);
        s_rdv = 1'b1; s_wrv = 1'b1; s_rdata = 32'h5555AAAA; s_resp = 2'b11;
        #1;
        chk("stray_idle_valid", {m_rdv, m_wrv}, 4'b0000);
        chk("stray_idle_data", m_rdata[0] | m_rdata[1], 32'd0);
        s_rdv = 1'b0; s_wrv = 1'b0; s_rdata = '0; s_resp = 2'b00;
        tick();

        for (int i = 0; i < 5; i++) run_xact(vecs[i]);

        // Simultaneous request after reset: m0 16-beat read wins, m1 write waits.
        clear_inputs();
        do_reset();
        m_read[0] = 1'b1; m_bc[0] = 5'd16; m_addr[0] = 30'h10;
        m_write[1] = 1'b1; m_bc[1] = 5'd1; m_addr[1] = 30'h20; m_be[1] = 4'b0011; m_wdata[1] = 32'hCAFEF00D;
        tick();
        chk("t2_owner_m0", owner, 2'b01);
        chk("t2_m1_wait_cmd", m_wait[1], 1'b1);
        tick();
        m_read[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            s_rdv = 1'b1; s_rdata = 32'(k);
            #1;
            chk("t2_m1_wait_resp", m_wait[1], 1'b1);
            chk("t2_m0_rdv", m_rdv, 2'b01);
            tick();
        end
        s_rdv = 1'b0;
        #1;
        chk("t2_no_same_cycle_grant", owner, 2'b00);
        tick();
        chk("t2_owner_m1", owner, 2'b10);
        chk("t2_s_write", s_write, 1'b1);
        chk("t2_wdata", s_writedata, 32'hCAFEF00D);
        chk("t2_be", s_byteenable, 4'b0011);
        tick();
        m_write[1] = 1'b0; s_wrv = 1'b1;
        #1;
        chk("t2_m1_wrv", m_wrv, 2'b10);
        tick();
        s_wrv = 1'b0;

        // Both masters keep requesting single reads: grants alternate.
        m_read = 2'b11; m_bc[0] = 5'd1; m_bc[1] = 5'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_owner", owner, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            s_rdv = 1'b1;
            tick();
            s_rdv = 1'b0;
        end
        m_read = 2'b00;
        tick();

        // m1 4-beat write with slave stalls on beat 2, then error response.
        acc_q.delete();
        mon_en = 1'b1;
        m_write[1] = 1'b1; m_bc[1] = 5'd4; m_wdata[1] = 32'hB0; m_be[1] = 4'hF;
        tick();
        chk("t4_owner", owner, 2'b10);
        tick();
        m_wdata[1] = 32'hB1;
        tick();
        m_wdata[1] = 32'hB2; s_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_stall_wait", m_wait[1], 1'b1);
            chk("t4_stall_write", s_write, 1'b1);
            tick();
        end
        s_waitrequest = 1'b0;
        tick();
        m_wdata[1] = 32'hB3;
        tick();
        m_write[1] = 1'b0; mon_en = 1'b0;
        #1;
        chk("t4_resp_no_write", s_write, 1'b0);
        chk("t4_beats", acc_q.size(), 4);
        for (int k = 0; k < 4; k++) chk("t4_beat_data", (k < acc_q.size()) ? acc_q[k] : 32'hX, 32'hB0 + 32'(k));
        s_wrv = 1'b1; s_resp = 2'b10;
        #1;
        chk("t4_wrv", m_wrv, 2'b10);
        chk("t4_resp", m_resp[1], 2'b10);
        tick();
        s_wrv = 1'b0; s_resp = 2'b00;
        #1;
        chk("t4_wrv_once", m_wrv, 2'b00);
        chk("t4_idle", owner, 2'b00);
        tick();

        // Reset during an 8-beat read response.
        m_read[0] = 1'b1; m_bc[0] = 5'd8;
        tick();
        tick();
        m_read[0] = 1'b0; s_rdv = 1'b1; s_rdata = 32'h77;
        #1;
        chk("t5_rdv_before", m_rdv[0], 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_owner", owner, 2'b00);
        chk("t5_wait", m_wait, 2'b11);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_dropped", m_rdv, 2'b00);
            chk("t5_data_zero", m_rdata[0], 32'd0);
            tick();
        end
        s_rdv = 1'b0; s_rdata = '0;

        // m0 abandons while stalled; m1 is granted the next cycle.
        m_read = 2'b11; m_bc[0] = 5'd1; m_bc[1] = 5'd1; m_addr[1] = 30'h1234;
        s_waitrequest = 1'b1;
        tick();
        chk("t6_owner_m0", owner, 2'b01);
        chk("t6_m0_stall", m_wait[0], 1'b1);
        s_rdv = 1'b1;
        #1;
        chk("t6_stray_cmd", m_rdv, 2'b00);
        s_rdv = 1'b0; m_read[0] = 1'b0;
        tick();
        chk("t6_abandon", owner, 2'b00);
        tick();
        chk("t6_owner_m1", owner, 2'b10);
        s_waitrequest = 1'b0;
        #1;
        chk("t6_s_read", s_read, 1'b1);
        chk("t6_addr", s_address, 30'h1234);
        tick();
        m_read[1] = 1'b0; s_rdv = 1'b1;
        #1;
        chk("t6_m1_rdv", m_rdv, 2'b10);
        tick();
        s_rdv = 1'b0;
        #1;
        chk("t6_idle", owner, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
